// File: rtl/axi_rd_arb_mux_if.sv
// axi_rd_arb_mux_if: master-facing (per-master vectors) and slave-facing read-channel bundles
interface axi_rd_arb_mux_m_if #(
    parameter int NUM_MASTERS = 4,
    parameter int DATA_WIDTH  = 64,
    parameter int ADDR_WIDTH  = 32,
    parameter int ID_WIDTH    = 8
);
    logic [NUM_MASTERS*ID_WIDTH-1:0]   ARID;
    logic [NUM_MASTERS*ADDR_WIDTH-1:0] ARADDR;
    logic [NUM_MASTERS*8-1:0]          ARLEN;
    logic [NUM_MASTERS*3-1:0]          ARSIZE;
    logic [NUM_MASTERS*2-1:0]          ARBURST;
    logic [NUM_MASTERS*4-1:0]          ARQOS;
    logic [NUM_MASTERS-1:0]            ARVALID;
    logic [NUM_MASTERS-1:0]            ARREADY;
    logic [DATA_WIDTH-1:0]             RDATA;
    logic [ID_WIDTH-1:0]               RID;
    logic [1:0]                        RRESP;
    logic                              RLAST;
    logic [NUM_MASTERS-1:0]            RVALID;
    logic [NUM_MASTERS-1:0]            RREADY;

    modport master (
        output ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARQOS, ARVALID, RREADY,
        input  ARREADY, RDATA, RID, RRESP, RLAST, RVALID
    );
    modport slave (
        input  ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARQOS, ARVALID, RREADY,
        output ARREADY, RDATA, RID, RRESP, RLAST, RVALID
    );
endinterface

interface axi_rd_arb_mux_s_if #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 32,
    parameter int ID_WIDTH   = 8
);
    logic [ID_WIDTH-1:0]   ARID;
    logic [ADDR_WIDTH-1:0] ARADDR;
    logic [7:0]            ARLEN;
    logic [2:0]            ARSIZE;
    logic [1:0]            ARBURST;
    logic [3:0]            ARQOS;
    logic                  ARVALID;
    logic                  ARREADY;
    logic [DATA_WIDTH-1:0] RDATA;
    logic [ID_WIDTH-1:0]   RID;
    logic [1:0]            RRESP;
    logic                  RLAST;
    logic                  RVALID;
    logic                  RREADY;

    modport master (
        output ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARQOS, ARVALID, RREADY,
        input  ARREADY, RDATA, RID, RRESP, RLAST, RVALID
    );
    modport slave (
        input  ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARQOS, ARVALID, RREADY,
        output ARREADY, RDATA, RID, RRESP, RLAST, RVALID
    );
endinterface

// File: rtl/axi_rd_arb_mux.sv
// axi_rd_arb_mux: N-master AXI4 read arbiter + AR/R mux, one burst in flight; AXI_RD_QOS_ARB_EN selects QoS-first arbitration
module axi_rd_arb_mux #(
    parameter int NUM_MASTERS = 4,
    parameter int DATA_WIDTH  = 64,
    parameter int ADDR_WIDTH  = 32,
    parameter int ID_WIDTH    = 8
) (
    input  logic                   ACLK,
    input  logic                   ARESETn,
    axi_rd_arb_mux_m_if.slave      m,
    axi_rd_arb_mux_s_if.master     s,
    output logic [NUM_MASTERS-1:0] rgrnt
);
    localparam int GW = $clog2(NUM_MASTERS);

    typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

    state_t                 r_state;
    logic [NUM_MASTERS-1:0] r_grnt;
    logic [GW-1:0]          r_owner;
    logic [GW-1:0]          r_last;

    logic [GW-1:0]          w_win;
    logic                   w_found;
    int                     w_idx;
`ifdef AXI_RD_QOS_ARB_EN
    logic [3:0]             w_best;
`endif
    logic                   w_busy;
    logic                   w_addr;
    logic                   w_data;
    logic                   w_arvalid;
    logic                   w_rready;
    logic                   w_ar_hs;
    logic                   w_r_done;

    if (NUM_MASTERS < 2 || NUM_MASTERS > 16) begin : g_bad_param
        $error("axi_rd_arb_mux: NUM_MASTERS must be in 2..16");
    end

    // Pick the next owner by scanning upward from just past the last owner, wrapping at N
    always_comb begin
        w_win   = r_last;
        w_found = 1'b0;
        w_idx   = 0;
`ifdef AXI_RD_QOS_ARB_EN
        w_best  = '0;
`endif
        for (int k = 1; k <= NUM_MASTERS; k++) begin
            w_idx = int'(r_last) + k;
            if (w_idx >= NUM_MASTERS) w_idx = w_idx - NUM_MASTERS;
`ifdef AXI_RD_QOS_ARB_EN
            // Strictly greater keeps the earliest requester in rotating order on a QoS tie
            if (m.ARVALID[w_idx] && (!w_found || m.ARQOS[w_idx*4 +: 4] > w_best)) begin
                w_found = 1'b1;
                w_best  = m.ARQOS[w_idx*4 +: 4];
                w_win   = GW'(w_idx);
            end
`else
            if (m.ARVALID[w_idx] && !w_found) begin
                w_found = 1'b1;
                w_win   = GW'(w_idx);
            end
`endif
        end
    end

    assign w_busy    = |r_grnt;
    assign w_addr    = (r_state == ADDR);
    assign w_data    = (r_state == DATA);
    assign w_arvalid = w_addr & m.ARVALID[r_owner];
    assign w_rready  = w_data & m.RREADY[r_owner];
    assign w_ar_hs   = w_arvalid & s.ARREADY;
    assign w_r_done  = w_data & s.RVALID & w_rready & s.RLAST;

    // Grant is held from AR selection until the RLAST beat completes
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_state <= IDLE;
            r_grnt  <= '0;
            r_owner <= '0;
            r_last  <= GW'(NUM_MASTERS - 1);
        end else begin
            case (r_state)
                IDLE: begin
                    if (|m.ARVALID) begin
                        r_state <= ADDR;
                        r_owner <= w_win;
                        r_grnt  <= NUM_MASTERS'(1) << w_win;
                    end
                end
                ADDR: begin
                    if (w_ar_hs) r_state <= DATA;
                end
                DATA: begin
                    if (w_r_done) begin
                        r_state <= IDLE;
                        r_last  <= r_owner;
                        r_grnt  <= '0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_grnt  <= '0;
                end
            endcase
        end
    end

    assign rgrnt = r_grnt;

    assign s.ARID    = w_busy ? m.ARID[r_owner*ID_WIDTH +: ID_WIDTH]       : '0;
    assign s.ARADDR  = w_busy ? m.ARADDR[r_owner*ADDR_WIDTH +: ADDR_WIDTH] : '0;
    assign s.ARLEN   = w_busy ? m.ARLEN[r_owner*8 +: 8]                    : '0;
    assign s.ARSIZE  = w_busy ? m.ARSIZE[r_owner*3 +: 3]                   : '0;
    assign s.ARBURST = w_busy ? m.ARBURST[r_owner*2 +: 2]                  : '0;
    assign s.ARQOS   = w_busy ? m.ARQOS[r_owner*4 +: 4]                    : '0;
    assign s.ARVALID = w_arvalid;
    assign s.RREADY  = w_rready;

    assign m.ARREADY = w_addr ? (r_grnt & {NUM_MASTERS{s.ARREADY}}) : '0;
    assign m.RVALID  = w_data ? (r_grnt & {NUM_MASTERS{s.RVALID}})  : '0;
    assign m.RDATA   = w_busy ? s.RDATA : '0;
    assign m.RID     = w_busy ? s.RID   : '0;
    assign m.RRESP   = w_busy ? s.RRESP : '0;
    assign m.RLAST   = w_busy ? s.RLAST : 1'b0;

    // Grant never names more than one master, and is present exactly while a burst is owned
    a_onehot: assert property (@(posedge ACLK) disable iff (!ARESETn) $onehot0(r_grnt));
    a_grant_state: assert property (@(posedge ACLK) disable iff (!ARESETn) (r_grnt != '0) == (r_state != IDLE));
endmodule

// File: tb/tb_axi_rd_arb_mux.sv
// tb_axi_rd_arb_mux: directed + randomized bench with a transaction-level arbitration model
module tb_axi_rd_arb_mux;
    localparam int N  = 4;
    localparam int DW = 64;
    localparam int AW = 32;
    localparam int IW = 8;

    logic         ACLK = 1'b0;
    logic         ARESETn = 1'b0;
    logic [N-1:0] rgrnt;

    int n_pass = 0;
    int n_total = 0;

    axi_rd_arb_mux_m_if #(.NUM_MASTERS(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ID_WIDTH(IW)) m_if ();
    axi_rd_arb_mux_s_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ID_WIDTH(IW)) s_if ();

    axi_rd_arb_mux #(.NUM_MASTERS(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ID_WIDTH(IW)) dut (
        .ACLK    (ACLK),
        .ARESETn (ARESETn),
        .m       (m_if),
        .s       (s_if),
        .rgrnt   (rgrnt)
    );

    always #5 ACLK = ~ACLK;

    // Model: owner of the current burst (-1 none), previous owner, address phase done
    int           own = -1;
    int           last = N - 1;
    bit           adone = 1'b0;
    bit           act_a;
    bit           dat;
    int           glog[$];
    logic [N-1:0] prev_g = '0;
    int           beats[N];
    logic [N-1:0] hs_mar = '0;
    bit           hs_sar = 1'b0;
    bit           hs_r = 1'b0;
    logic [7:0]   cap_len = '0;
    logic [IW-1:0] cap_id = '0;

    // Stimulus knobs and slave model
    logic [N-1:0] hold = '0;
    bit           rnd_req = 1'b0;
    bit           rr_rand = 1'b0;
    int           req_p = 0;
    int           ar_p = 100;
    int           rv_p = 100;
    int           sl_beats = 0;
    logic [IW-1:0] sl_id = '0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    endtask

    function automatic int pick(input logic [N-1:0] v, input logic [N*4-1:0] q, input int lst);
        int best = -1;
        int bq = -1;
        for (int k = 1; k <= N; k++) begin
            int i = (lst + k) % N;
            if (v[i]) begin
`ifdef AXI_RD_QOS_ARB_EN
                if (best < 0 || int'(q[i*4 +: 4]) > bq) begin
                    best = i;
                    bq = int'(q[i*4 +: 4]);
                end
`else
                if (best < 0) begin
                    best = i;
                    bq = int'(q[i*4 +: 4]);
                end
`endif
            end
        end
        return best;
    endfunction

    // Compare DUT outputs with the model mid-cycle, then advance the model to the next edge
    always @(negedge ACLK) begin
        if (!ARESETn) begin
            own = -1;
            last = N - 1;
            adone = 1'b0;
            prev_g = '0;
            hs_mar = '0;
            hs_sar = 1'b0;
            hs_r = 1'b0;
        end else begin
            act_a = (own >= 0) && !adone;
            dat = (own >= 0) && adone;
            chk("rgrnt", 128'(rgrnt), own >= 0 ? (128'(1) << own) : '0);
            chk("s_ARVALID", 128'(s_if.ARVALID), act_a ? 128'(m_if.ARVALID[own]) : '0);
            chk("m_ARREADY", 128'(m_if.ARREADY), (act_a && s_if.ARREADY) ? (128'(1) << own) : '0);
            chk("s_ARADDR", 128'(s_if.ARADDR), own >= 0 ? 128'(m_if.ARADDR[own*AW +: AW]) : '0);
            chk("s_ARID", 128'(s_if.ARID), own >= 0 ? 128'(m_if.ARID[own*IW +: IW]) : '0);
            chk("s_ARLEN", 128'(s_if.ARLEN), own >= 0 ? 128'(m_if.ARLEN[own*8 +: 8]) : '0);
            chk("s_ARQOS", 128'(s_if.ARQOS), own >= 0 ? 128'(m_if.ARQOS[own*4 +: 4]) : '0);
            chk("s_ARSIZE_BURST", 128'({s_if.ARSIZE, s_if.ARBURST}),
                own >= 0 ? 128'({m_if.ARSIZE[own*3 +: 3], m_if.ARBURST[own*2 +: 2]}) : '0);
            chk("m_RVALID", 128'(m_if.RVALID), (dat && s_if.RVALID) ? (128'(1) << own) : '0);
            chk("s_RREADY", 128'(s_if.RREADY), dat ? 128'(m_if.RREADY[own]) : '0);
            chk("m_RDATA", 128'(m_if.RDATA), own >= 0 ? 128'(s_if.RDATA) : '0);
            chk("m_RID_RESP_LAST", 128'({m_if.RID, m_if.RRESP, m_if.RLAST}),
                own >= 0 ? 128'({s_if.RID, s_if.RRESP, s_if.RLAST}) : '0);
            if (rgrnt != '0 && prev_g == '0)
                for (int i = 0; i < N; i++) if (rgrnt[i]) glog.push_back(i);
            prev_g = rgrnt;
            hs_mar = m_if.ARVALID & m_if.ARREADY;
            hs_sar = s_if.ARVALID & s_if.ARREADY;
            hs_r = s_if.RVALID & s_if.RREADY;
            cap_len = s_if.ARLEN;
            cap_id = s_if.ARID;
            for (int i = 0; i < N; i++) if (m_if.RVALID[i] && m_if.RREADY[i]) beats[i]++;
            if (own < 0) begin
                own = pick(m_if.ARVALID, m_if.ARQOS, last);
                adone = 1'b0;
            end else if (!adone) begin
                if (m_if.ARVALID[own] && s_if.ARREADY) adone = 1'b1;
            end else if (s_if.RVALID && m_if.RREADY[own] && s_if.RLAST) begin
                last = own;
                own = -1;
            end
        end
    end

    task automatic new_req(input int i, input int len, input int qos);
        m_if.ARVALID[i] = 1'b1;
        m_if.ARID[i*IW +: IW] = IW'($urandom);
        m_if.ARADDR[i*AW +: AW] = $urandom;
        m_if.ARLEN[i*8 +: 8] = 8'(len);
        m_if.ARSIZE[i*3 +: 3] = 3'($urandom);
        m_if.ARBURST[i*2 +: 2] = 2'($urandom);
        m_if.ARQOS[i*4 +: 4] = 4'(qos);
    endtask

    // Advance one clock and let masters/slave react to the handshakes seen in that cycle
    task automatic step();
        @(posedge ACLK);
        #1;
        for (int i = 0; i < N; i++) begin
            if (hs_mar[i] && !hold[i]) m_if.ARVALID[i] = 1'b0;
            if (rnd_req && !m_if.ARVALID[i] && int'($urandom_range(99)) < req_p)
                new_req(i, int'($urandom_range(7)), int'($urandom_range(15)));
        end
        if (hs_sar) begin
            sl_beats = int'(cap_len) + 1;
            sl_id = cap_id;
        end
        if (hs_r) sl_beats--;
        if (!(s_if.RVALID && !hs_r)) begin
            s_if.RVALID = (sl_beats > 0) && (int'($urandom_range(99)) < rv_p);
            s_if.RDATA = {$urandom, $urandom};
            s_if.RID = s_if.RVALID ? sl_id : IW'($urandom);
            s_if.RRESP = 2'($urandom);
            s_if.RLAST = s_if.RVALID ? (sl_beats == 1) : 1'($urandom);
        end
        s_if.ARREADY = int'($urandom_range(99)) < ar_p;
        if (rr_rand) m_if.RREADY = N'($urandom);
    endtask

    task automatic do_reset();
        ARESETn = 1'b0;
        m_if.ARVALID = '0;
        hold = '0;
        rnd_req = 1'b0;
        rr_rand = 1'b0;
        m_if.RREADY = '1;
        ar_p = 100;
        rv_p = 100;
        s_if.RVALID = 1'b0;
        s_if.RLAST = 1'b0;
        s_if.ARREADY = 1'b1;
        sl_beats = 0;
        step();
        step();
        ARESETn = 1'b1;
    endtask

    task automatic wait_done(input int budget, input string name);
        int c = 0;
        while ((m_if.ARVALID != '0 || rgrnt != '0 || sl_beats != 0) && c < budget) begin
            step();
            c++;
        end
        chk({name, "_in_time"}, 128'(c < budget), 128'(1));
    endtask

    task automatic wait_grants(input int target, input int budget, input string name);
        int c = 0;
        while (glog.size() < target && c < budget) begin
            step();
            c++;
        end
        chk({name, "_grants_in_time"}, 128'(c < budget), 128'(1));
    endtask

    task automatic chk_log(input string name, input int idx, input int exp);
        int got = (glog.size() > idx) ? glog[idx] : -1;
        chk(name, 128'(got), 128'(exp));
    endtask

    initial begin
        int b;
        int c;
        m_if.ARVALID = '0;
        m_if.ARID = '0;
        m_if.ARADDR = '0;
        m_if.ARLEN = '0;
        m_if.ARSIZE = '0;
        m_if.ARBURST = '0;
        m_if.ARQOS = '0;
        m_if.RREADY = '1;
        s_if.ARREADY = 1'b1;
        s_if.RDATA = '0;
        s_if.RID = '0;
        s_if.RRESP = '0;
        s_if.RLAST = 1'b0;
        s_if.RVALID = 1'b0;
        for (int i = 0; i < N; i++) beats[i] = 0;

        // Reset values and a single 4-beat burst from m0
        do_reset();
        chk("rst_rgrnt", 128'(rgrnt), 128'(0));
        chk("rst_s_ARVALID", 128'(s_if.ARVALID), 128'(0));
        chk("rst_s_RREADY", 128'(s_if.RREADY), 128'(0));
        b = beats[0];
        new_req(0, 3, 0);
        m_if.ARADDR[0 +: AW] = 32'h1000_0040;
        step();
        chk("t1_rgrnt", 128'(rgrnt), 128'(4'b0001));
        chk("t1_s_ARADDR", 128'(s_if.ARADDR), 128'(32'h1000_0040));
        chk("t1_s_ARVALID", 128'(s_if.ARVALID), 128'(1));
        wait_done(60, "t1");
        chk("t1_beats_m0", 128'(beats[0] - b), 128'(4));
        chk("t1_rgrnt_end", 128'(rgrnt), 128'(0));

        // All four requesting continuously with single-beat bursts
        do_reset();
        b = glog.size();
        hold = '1;
        for (int i = 0; i < N; i++) new_req(i, 0, 0);
        wait_grants(b + 5, 100, "t2");
        hold = '0;
        wait_done(100, "t2");
        chk_log("t2_g0", b, 0);
        chk_log("t2_g1", b + 1, 1);
        chk_log("t2_g2", b + 2, 2);
        chk_log("t2_g3", b + 3, 3);
        chk_log("t2_g4", b + 4, 0);

        // Last owner 3, then m1 and m2 together
        do_reset();
        b = glog.size();
        new_req(3, 0, 0);
        wait_done(50, "t3a");
        new_req(1, 1, 0);
        new_req(2, 1, 0);
        wait_done(80, "t3b");
        chk_log("t3_g0", b, 3);
        chk_log("t3_g1", b + 1, 1);
        chk_log("t3_g2", b + 2, 2);

        // Owner RREADY low for two cycles mid-burst; non-owner RREADY toggles
        do_reset();
        b = beats[1];
        new_req(1, 3, 0);
        c = 0;
        while (beats[1] - b < 1 && c < 30) begin
            step();
            c++;
        end
        chk("t4_first_beat_in_time", 128'(c < 30), 128'(1));
        m_if.RREADY = 4'b1101;
        #1;
        chk("t4_s_RREADY_low0", 128'(s_if.RREADY), 128'(0));
        step();
        m_if.RREADY = 4'b0100;
        #1;
        chk("t4_s_RREADY_low1", 128'(s_if.RREADY), 128'(0));
        chk("t4_m_RVALID_held", 128'(m_if.RVALID), 128'(4'b0010));
        step();
        m_if.RREADY = 4'b1010;
        #1;
        chk("t4_s_RREADY_back", 128'(s_if.RREADY), 128'(1));
        wait_done(60, "t4");
        chk("t4_beats_m1", 128'(beats[1] - b), 128'(4));

        // Reset during beat 2 of an 8-beat burst
        do_reset();
        b = beats[0];
        new_req(0, 7, 0);
        c = 0;
        while (beats[0] - b < 2 && c < 30) begin
            step();
            c++;
        end
        chk("t5_two_beats_in_time", 128'(c < 30), 128'(1));
        ARESETn = 1'b0;
        #1;
        chk("t5_rgrnt", 128'(rgrnt), 128'(0));
        chk("t5_s_ARVALID", 128'(s_if.ARVALID), 128'(0));
        chk("t5_s_RREADY", 128'(s_if.RREADY), 128'(0));
        chk("t5_m_RVALID", 128'(m_if.RVALID), 128'(0));
        m_if.ARVALID = '0;
        s_if.RVALID = 1'b0;
        sl_beats = 0;
        step();
        step();
        ARESETn = 1'b1;
        b = glog.size();
        new_req(0, 0, 0);
        new_req(3, 0, 0);
        wait_done(60, "t5");
        chk_log("t5_g0", b, 0);
        chk_log("t5_g1", b + 1, 3);

        // QoS scenario with last owner 2
        do_reset();
        new_req(2, 0, 7);
        wait_done(50, "t6a");
        b = glog.size();
        new_req(0, 0, 1);
        new_req(2, 0, 7);
        new_req(3, 0, 7);
        wait_done(100, "t6b");
        chk_log("t6_g0", b, 3);
`ifdef AXI_RD_QOS_ARB_EN
        chk_log("t6_g1", b + 1, 2);
        chk_log("t6_g2", b + 2, 0);
`else
        chk_log("t6_g1", b + 1, 0);
        chk_log("t6_g2", b + 2, 2);
`endif

        // Randomized traffic and backpressure
        do_reset();
        rnd_req = 1'b1;
        rr_rand = 1'b1;
        req_p = 30;
        ar_p = 60;
        rv_p = 70;
        repeat (3000) step();
        rnd_req = 1'b0;
        wait_done(2000, "rand");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
